// File: rtl/alu_pkg.sv
// Shared constants for the integer ALU and its execute-stage issue controller:
// ALU operation codes, RV64I opcode/funct fields, compare kinds and FSM states.
package alu_pkg;

  localparam int DEF_WORDSIZE = 64;
  localparam int DEF_SHAMT_W  = 6;

  localparam logic [5:0] ALU_ADD = 6'b00_0000;
  localparam logic [5:0] ALU_SUB = 6'b00_0001;
  localparam logic [5:0] ALU_AND = 6'b10_0000;
  localparam logic [5:0] ALU_OR  = 6'b10_0001;
  localparam logic [5:0] ALU_XOR = 6'b10_0011;
  localparam logic [5:0] ALU_SLL = 6'b11_0011;
  localparam logic [5:0] ALU_SRL = 6'b11_0010;
  localparam logic [5:0] ALU_SRA = 6'b11_0000;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE     = 7'b0000000;
  localparam logic [6:0] F7_ALT      = 7'b0100000;
  localparam logic [5:0] F7H_SH_BASE = 6'b000000;
  localparam logic [5:0] F7H_SH_ALT  = 6'b010000;

  typedef enum logic [3:0] {
    CMP_NONE,
    CMP_SLT,
    CMP_SLTU,
    CMP_BEQ,
    CMP_BNE,
    CMP_BLT,
    CMP_BGE,
    CMP_BLTU,
    CMP_BGEU
  } cmp_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of an RV64I OP / OP-IMM / BRANCH encoding into the ALU
// operation, operand-B selection and the compare kind used to form the response.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [5:0] alu_operation,
  output logic       use_imm,
  output logic       shift_operand,
  output cmp_kind_e  cmp_kind,
  output logic       illegal
);

  always_comb begin
    alu_operation = ALU_ADD;
    use_imm       = 1'b0;
    shift_operand = 1'b0;
    cmp_kind      = CMP_NONE;
    illegal       = 1'b0;

    unique case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          unique case (funct3)
            F3_ADD:  alu_operation = ALU_ADD;
            F3_SLL:  begin alu_operation = ALU_SLL; shift_operand = 1'b1; end
            F3_SLT:  begin alu_operation = ALU_SUB; cmp_kind = CMP_SLT; end
            F3_SLTU: begin alu_operation = ALU_SUB; cmp_kind = CMP_SLTU; end
            F3_XOR:  alu_operation = ALU_XOR;
            F3_SR:   begin alu_operation = ALU_SRL; shift_operand = 1'b1; end
            F3_OR:   alu_operation = ALU_OR;
            F3_AND:  alu_operation = ALU_AND;
            default: illegal = 1'b1;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          alu_operation = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          alu_operation = ALU_SRA;
          shift_operand = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end

      // funct7 here is imm[11:5]; only the shift forms constrain it, and
      // funct7[0] is shamt[5] on RV64 so it is not part of the check.
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        unique case (funct3)
          F3_ADD:  alu_operation = ALU_ADD;
          F3_SLT:  begin alu_operation = ALU_SUB; cmp_kind = CMP_SLT; end
          F3_SLTU: begin alu_operation = ALU_SUB; cmp_kind = CMP_SLTU; end
          F3_XOR:  alu_operation = ALU_XOR;
          F3_OR:   alu_operation = ALU_OR;
          F3_AND:  alu_operation = ALU_AND;
          F3_SLL: begin
            alu_operation = ALU_SLL;
            shift_operand = 1'b1;
            illegal       = (funct7[6:1] != F7H_SH_BASE);
          end
          F3_SR: begin
            shift_operand = 1'b1;
            if (funct7[6:1] == F7H_SH_BASE)     alu_operation = ALU_SRL;
            else if (funct7[6:1] == F7H_SH_ALT) alu_operation = ALU_SRA;
            else                                illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end

      OPC_BRANCH: begin
        alu_operation = ALU_SUB;
        unique case (funct3)
          F3_BEQ:  cmp_kind = CMP_BEQ;
          F3_BNE:  cmp_kind = CMP_BNE;
          F3_BLT:  cmp_kind = CMP_BLT;
          F3_BGE:  cmp_kind = CMP_BGE;
          F3_BLTU: cmp_kind = CMP_BLTU;
          F3_BGEU: cmp_kind = CMP_BGEU;
          default: illegal = 1'b1;
        endcase
      end

      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage controller: accepts one decoded integer request, drives the
// combinational ALU for one cycle, then holds the result/branch decision.
//   state   | meaning
//   IDLE    | req_ready=1, waiting for a request
//   EXEC    | ALU inputs driven from latched operands; result captured at edge
//   RESP    | rsp_valid=1, response held until rsp_ready
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WORDSIZE = DEF_WORDSIZE,
  parameter int SHAMT_W  = DEF_SHAMT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [6:0]          req_opcode,
  input  logic [2:0]          req_funct3,
  input  logic [6:0]          req_funct7,
  input  logic [WORDSIZE-1:0] req_rs1,
  input  logic [WORDSIZE-1:0] req_rs2,
  input  logic [WORDSIZE-1:0] req_imm,
  output logic [WORDSIZE-1:0] alu_input_a,
  output logic [WORDSIZE-1:0] alu_input_b,
  output logic [5:0]          alu_operation,
  input  logic [WORDSIZE-1:0] alu_result,
  input  logic                alu_flag_overflow,
  input  logic                alu_flag_equal,
  input  logic                alu_flag_not_equal,
  input  logic                alu_flag_less,
  input  logic                alu_flag_u_less,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WORDSIZE-1:0] rsp_result,
  output logic                rsp_branch_taken,
  output logic                rsp_overflow,
  output logic                rsp_illegal
);

  state_e              state_q, state_d;
  logic [WORDSIZE-1:0] a_q, a_d, b_q, b_d;
  logic [5:0]          op_q, op_d;
  cmp_kind_e           cmp_q, cmp_d;
  logic                ovf_en_q, ovf_en_d;
  logic [WORDSIZE-1:0] result_q, result_d;
  logic                taken_q, taken_d;
  logic                ovf_q, ovf_d;
  logic                illegal_q, illegal_d;

  logic [5:0]          dec_op;
  logic                dec_use_imm;
  logic                dec_shift;
  cmp_kind_e           dec_cmp;
  logic                dec_illegal;
  logic [WORDSIZE-1:0] opnd_src;
  logic [WORDSIZE-1:0] opnd_b;

  alu_op_decode u_decode (
    .opcode        (req_opcode),
    .funct3        (req_funct3),
    .funct7        (req_funct7),
    .alu_operation (dec_op),
    .use_imm       (dec_use_imm),
    .shift_operand (dec_shift),
    .cmp_kind      (dec_cmp),
    .illegal       (dec_illegal)
  );

  assign opnd_src = dec_use_imm ? req_imm : req_rs2;
  assign opnd_b   = dec_shift ? {{(WORDSIZE-SHAMT_W){1'b0}}, opnd_src[SHAMT_W-1:0]}
                              : opnd_src;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    cmp_d     = cmp_q;
    ovf_en_d  = ovf_en_q;
    result_d  = result_q;
    taken_d   = taken_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (dec_illegal) begin
            // Nothing is issued to the ALU; its inputs keep their last value.
            result_d  = '0;
            taken_d   = 1'b0;
            ovf_d     = 1'b0;
            illegal_d = 1'b1;
            state_d   = ST_RESP;
          end else begin
            a_d      = req_rs1;
            b_d      = opnd_b;
            op_d     = dec_op;
            cmp_d    = dec_cmp;
            ovf_en_d = (dec_cmp == CMP_NONE) && (dec_op == ALU_ADD || dec_op == ALU_SUB);
            state_d  = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        unique case (cmp_q)
          CMP_NONE: result_d = alu_result;
          CMP_SLT:  result_d = {{(WORDSIZE-1){1'b0}}, alu_flag_less};
          CMP_SLTU: result_d = {{(WORDSIZE-1){1'b0}}, alu_flag_u_less};
          default:  result_d = '0;
        endcase
        unique case (cmp_q)
          CMP_BEQ:  taken_d = alu_flag_equal;
          CMP_BNE:  taken_d = alu_flag_not_equal;
          CMP_BLT:  taken_d = alu_flag_less;
          CMP_BGE:  taken_d = ~alu_flag_less;
          CMP_BLTU: taken_d = alu_flag_u_less;
          CMP_BGEU: taken_d = ~alu_flag_u_less;
          default:  taken_d = 1'b0;
        endcase
        ovf_d     = ovf_en_q & alu_flag_overflow;
        illegal_d = 1'b0;
        state_d   = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= ALU_ADD;
      cmp_q     <= CMP_NONE;
      ovf_en_q  <= 1'b0;
      result_q  <= '0;
      taken_q   <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cmp_q     <= cmp_d;
      ovf_en_q  <= ovf_en_d;
      result_q  <= result_d;
      taken_q   <= taken_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
    end
  end

  assign req_ready        = (state_q == ST_IDLE);
  assign rsp_valid        = (state_q == ST_RESP);
  assign alu_input_a      = a_q;
  assign alu_input_b      = b_q;
  assign alu_operation    = op_q;
  assign rsp_result       = result_q;
  assign rsp_branch_taken = taken_q;
  assign rsp_overflow     = ovf_q;
  assign rsp_illegal      = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, directed vector table, a reset-
// during-response sequence and randomized requests against a reference model.
module tb_alu_issue_ctrl;

  localparam logic [6:0] T_OP  = 7'b0110011;
  localparam logic [6:0] T_IMM = 7'b0010011;
  localparam logic [6:0] T_BR  = 7'b1100011;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [6:0]  req_opcode, req_funct7;
  logic [2:0]  req_funct3;
  logic [63:0] req_rs1, req_rs2, req_imm;
  logic [63:0] alu_input_a, alu_input_b, alu_result;
  logic [5:0]  alu_operation;
  logic        alu_flag_overflow, alu_flag_equal, alu_flag_not_equal, alu_flag_less, alu_flag_u_less;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_branch_taken, rsp_overflow, rsp_illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .alu_input_a(alu_input_a), .alu_input_b(alu_input_b), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_flag_overflow(alu_flag_overflow),
    .alu_flag_equal(alu_flag_equal), .alu_flag_not_equal(alu_flag_not_equal),
    .alu_flag_less(alu_flag_less), .alu_flag_u_less(alu_flag_u_less),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_branch_taken(rsp_branch_taken), .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal)
  );

  // Behavioural combinational ALU.
  always_comb begin
    alu_result = '0;
    case (alu_operation)
      6'h00:   alu_result = alu_input_a + alu_input_b;
      6'h01:   alu_result = alu_input_a - alu_input_b;
      6'h20:   alu_result = alu_input_a & alu_input_b;
      6'h21:   alu_result = alu_input_a | alu_input_b;
      6'h23:   alu_result = alu_input_a ^ alu_input_b;
      6'h33:   alu_result = alu_input_a << alu_input_b[5:0];
      6'h32:   alu_result = alu_input_a >> alu_input_b[5:0];
      6'h30:   alu_result = $signed(alu_input_a) >>> alu_input_b[5:0];
      default: alu_result = '0;
    endcase
    alu_flag_overflow = 1'b0;
    if (alu_operation == 6'h00)
      alu_flag_overflow = (alu_input_a[63] == alu_input_b[63]) && (alu_result[63] != alu_input_a[63]);
    else if (alu_operation == 6'h01)
      alu_flag_overflow = (alu_input_a[63] != alu_input_b[63]) && (alu_result[63] != alu_input_a[63]);
    alu_flag_equal     = (alu_input_a == alu_input_b);
    alu_flag_not_equal = (alu_input_a != alu_input_b);
    alu_flag_less      = ($signed(alu_input_a) < $signed(alu_input_b));
    alu_flag_u_less    = (alu_input_a < alu_input_b);
  end

  typedef struct packed {
    logic [5:0]  op;
    logic [63:0] b;
    logic [63:0] result;
    logic        taken;
    logic        ovf;
    logic        illegal;
  } exp_t;

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] rs1, rs2, imm;
    exp_t        e;
  } vec_t;

  typedef enum int {K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND, K_BR, K_ILL} kind_e;

  function automatic vec_t mk(input string name, input logic [6:0] opc, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [63:0] rs1, input logic [63:0] rs2,
                              input logic [63:0] imm, input logic [5:0] op, input logic [63:0] b,
                              input logic [63:0] result, input logic taken, input logic ovf,
                              input logic ill);
    vec_t v;
    v.name = name; v.opc = opc; v.f3 = f3; v.f7 = f7;
    v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.e.op = op; v.e.b = b; v.e.result = result;
    v.e.taken = taken; v.e.ovf = ovf; v.e.illegal = ill;
    return v;
  endfunction

  // Reference: classify the instruction by name, then evaluate it arithmetically.
  function automatic exp_t ref_model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm);
    exp_t        e;
    kind_e       k;
    logic [63:0] opb;
    logic [64:0] wide;
    e = '0;
    k = K_ILL;
    opb = (opc == T_IMM) ? imm : rs2;
    if (opc == T_OP) begin
      if (f7 == 7'h00) begin
        case (f3)
          3'd0: k = K_ADD;  3'd1: k = K_SLL; 3'd2: k = K_SLT; 3'd3: k = K_SLTU;
          3'd4: k = K_XOR;  3'd5: k = K_SRL; 3'd6: k = K_OR;  default: k = K_AND;
        endcase
      end else if (f7 == 7'h20) begin
        k = (f3 == 3'd0) ? K_SUB : (f3 == 3'd5) ? K_SRA : K_ILL;
      end
    end else if (opc == T_IMM) begin
      case (f3)
        3'd0: k = K_ADD;  3'd2: k = K_SLT; 3'd3: k = K_SLTU;
        3'd4: k = K_XOR;  3'd6: k = K_OR;  3'd7: k = K_AND;
        3'd1: k = (f7[6:1] == 6'd0) ? K_SLL : K_ILL;
        default: k = (f7[6:1] == 6'd0) ? K_SRL : (f7[6:1] == 6'b010000) ? K_SRA : K_ILL;
      endcase
    end else if (opc == T_BR) begin
      k = (f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_BR;
    end
    if (k == K_ILL) begin
      e.illegal = 1'b1;
      return e;
    end
    if (k == K_SLL || k == K_SRL || k == K_SRA) opb = {58'd0, opb[5:0]};
    e.b = opb;
    case (k)
      K_ADD: begin
        e.op = 6'h00; e.result = rs1 + opb;
        wide = {rs1[63], rs1} + {opb[63], opb};
        e.ovf = wide[64] ^ wide[63];
      end
      K_SUB: begin
        e.op = 6'h01; e.result = rs1 - opb;
        wide = {rs1[63], rs1} - {opb[63], opb};
        e.ovf = wide[64] ^ wide[63];
      end
      K_SLT:  begin e.op = 6'h01; e.result = {63'd0, $signed(rs1) < $signed(opb)}; end
      K_SLTU: begin e.op = 6'h01; e.result = {63'd0, rs1 < opb}; end
      K_XOR:  begin e.op = 6'h23; e.result = rs1 ^ opb; end
      K_OR:   begin e.op = 6'h21; e.result = rs1 | opb; end
      K_AND:  begin e.op = 6'h20; e.result = rs1 & opb; end
      K_SLL:  begin e.op = 6'h33; e.result = rs1 << opb[5:0]; end
      K_SRL:  begin e.op = 6'h32; e.result = rs1 >> opb[5:0]; end
      K_SRA:  begin e.op = 6'h30; e.result = $signed(rs1) >>> opb[5:0]; end
      default: begin
        e.op = 6'h01;
        case (f3)
          3'd0: e.taken = (rs1 == rs2);
          3'd1: e.taken = (rs1 != rs2);
          3'd4: e.taken = ($signed(rs1) < $signed(rs2));
          3'd5: e.taken = !($signed(rs1) < $signed(rs2));
          3'd6: e.taken = (rs1 < rs2);
          default: e.taken = !(rs1 < rs2);
        endcase
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic scramble_req();
    req_opcode = 7'($urandom);
    req_funct3 = 3'($urandom);
    req_funct7 = 7'($urandom);
    req_rs1    = {$urandom, $urandom};
    req_rs2    = {$urandom, $urandom};
    req_imm    = {$urandom, $urandom};
  endtask

  task automatic run_txn(input vec_t v, input int hold);
    logic [5:0]  op0;
    logic [63:0] a0;
    int          lat;
    op0 = alu_operation;
    a0  = alu_input_a;
    chk({v.name, " req_ready_idle"}, 64'(req_ready), 64'd1);
    rsp_ready  = (hold == 0);
    req_valid  = 1'b1;
    req_opcode = v.opc; req_funct3 = v.f3; req_funct7 = v.f7;
    req_rs1 = v.rs1; req_rs2 = v.rs2; req_imm = v.imm;
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble_req();
    lat = 1;
    if (!v.e.illegal && !rsp_valid) begin
      chk({v.name, " alu_op"}, 64'(alu_operation), 64'(v.e.op));
      chk({v.name, " alu_a"}, alu_input_a, v.rs1);
      chk({v.name, " alu_b"}, alu_input_b, v.e.b);
    end
    while (!rsp_valid && lat < 6) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({v.name, " latency"}, 64'(lat), v.e.illegal ? 64'd1 : 64'd2);
    if (v.e.illegal) begin
      chk({v.name, " alu_op_kept"}, 64'(alu_operation), 64'(op0));
      chk({v.name, " alu_a_kept"}, alu_input_a, a0);
    end
    chk({v.name, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({v.name, " result"}, rsp_result, v.e.result);
    chk({v.name, " taken"}, 64'(rsp_branch_taken), 64'(v.e.taken));
    chk({v.name, " overflow"}, 64'(rsp_overflow), 64'(v.e.ovf));
    chk({v.name, " illegal"}, 64'(rsp_illegal), 64'(v.e.illegal));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({v.name, " hold_valid"}, 64'(rsp_valid), 64'd1);
      chk({v.name, " hold_result"}, rsp_result, v.e.result);
      chk({v.name, " hold_ready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk({v.name, " back_idle"}, 64'(req_ready), 64'd1);
    chk({v.name, " valid_drop"}, 64'(rsp_valid), 64'd0);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_opcode = '0; req_funct3 = '0; req_funct7 = '0;
    req_rs1 = '0; req_rs2 = '0; req_imm = '0;

    tbl.push_back(mk("add", T_OP, 3'd0, 7'h00, 64'd5, 64'd7, 64'd0, 6'h00, 64'd7, 64'd12, 0, 0, 0));
    tbl.push_back(mk("sub_ovf", T_OP, 3'd0, 7'h20, MINV, 64'd1, 64'd0, 6'h01, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 0));
    tbl.push_back(mk("srai", T_IMM, 3'd5, 7'h20, 64'hF000_0000_0000_0000, 64'h55, 64'h404, 6'h30, 64'd4, 64'hFF00_0000_0000_0000, 0, 0, 0));
    tbl.push_back(mk("bltu", T_BR, 3'd6, 7'h00, 64'd1, ONES, 64'd0, 6'h01, ONES, 64'd0, 1, 0, 0));
    tbl.push_back(mk("blt", T_BR, 3'd4, 7'h00, 64'd1, ONES, 64'd0, 6'h01, ONES, 64'd0, 0, 0, 0));
    tbl.push_back(mk("load_ill", 7'b0000011, 3'd3, 7'h00, 64'd9, 64'd9, 64'd0, 6'h00, 64'd0, 64'd0, 0, 0, 1));
    tbl.push_back(mk("add_ovf", T_OP, 3'd0, 7'h00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 6'h00, 64'd1, MINV, 0, 1, 0));
    tbl.push_back(mk("sll", T_OP, 3'd1, 7'h00, 64'd1, 64'd67, 64'd0, 6'h33, 64'd3, 64'd8, 0, 0, 0));
    tbl.push_back(mk("srl", T_OP, 3'd5, 7'h00, 64'h80, 64'd4, 64'd0, 6'h32, 64'd4, 64'd8, 0, 0, 0));
    tbl.push_back(mk("xor", T_OP, 3'd4, 7'h00, 64'hF0, 64'h3C, 64'd0, 6'h23, 64'h3C, 64'hCC, 0, 0, 0));
    tbl.push_back(mk("or", T_OP, 3'd6, 7'h00, 64'hF0, 64'h0F, 64'd0, 6'h21, 64'h0F, 64'hFF, 0, 0, 0));
    tbl.push_back(mk("and", T_OP, 3'd7, 7'h00, 64'hF0, 64'h3C, 64'd0, 6'h20, 64'h3C, 64'h30, 0, 0, 0));
    tbl.push_back(mk("slt", T_OP, 3'd2, 7'h00, ONES, 64'd1, 64'd0, 6'h01, 64'd1, 64'd1, 0, 0, 0));
    tbl.push_back(mk("sltu", T_OP, 3'd3, 7'h00, ONES, 64'd1, 64'd0, 6'h01, 64'd1, 64'd0, 0, 0, 0));
    tbl.push_back(mk("addi", T_IMM, 3'd0, 7'h7F, 64'd10, 64'd3, ONES, 6'h00, ONES, 64'd9, 0, 0, 0));
    tbl.push_back(mk("slli_bad", T_IMM, 3'd1, 7'h20, 64'd1, 64'd1, 64'h401, 6'h00, 64'd0, 64'd0, 0, 0, 1));
    tbl.push_back(mk("op_f7_ill", T_OP, 3'd0, 7'h01, 64'd1, 64'd1, 64'd0, 6'h00, 64'd0, 64'd0, 0, 0, 1));
    tbl.push_back(mk("br_f3_ill", T_BR, 3'd2, 7'h00, 64'd1, 64'd1, 64'd0, 6'h00, 64'd0, 64'd0, 0, 0, 1));
    tbl.push_back(mk("beq", T_BR, 3'd0, 7'h00, 64'h1234, 64'h1234, 64'd0, 6'h01, 64'h1234, 64'd0, 1, 0, 0));
    tbl.push_back(mk("bgeu", T_BR, 3'd7, 7'h00, 64'd1, ONES, 64'd0, 6'h01, ONES, 64'd0, 0, 0, 0));
    tbl.push_back(mk("srli", T_IMM, 3'd5, 7'h00, 64'hF000_0000_0000_0000, 64'd0, 64'd4, 6'h32, 64'd4, 64'h0F00_0000_0000_0000, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst req_ready", 64'(req_ready), 64'd1);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst rsp_result", rsp_result, 64'd0);
    chk("rst rsp_flags", {61'd0, rsp_branch_taken, rsp_overflow, rsp_illegal}, 64'd0);
    chk("rst alu_op", 64'(alu_operation), 64'd0);
    chk("rst alu_ab", alu_input_a | alu_input_b, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) run_txn(tbl[i], (i % 4 == 1) ? 2 : 0);

    // Reset while a response is stalled, with a competing request pending.
    v = mk("stall_add", T_OP, 3'd0, 7'h00, 64'd5, 64'd7, 64'd0, 6'h00, 64'd7, 64'd12, 0, 0, 0);
    rsp_ready  = 1'b0;
    req_valid  = 1'b1;
    req_opcode = v.opc; req_funct3 = v.f3; req_funct7 = v.f7;
    req_rs1 = v.rs1; req_rs2 = v.rs2; req_imm = v.imm;
    @(posedge clk); #1;
    req_opcode = T_OP; req_funct3 = 3'd4; req_rs1 = 64'hAAAA; req_rs2 = 64'h5555;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      chk("stall rsp_valid", 64'(rsp_valid), 64'd1);
      chk("stall req_ready", 64'(req_ready), 64'd0);
      chk("stall result", rsp_result, 64'd12);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 1'b0;
    chk("rst_resp rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_resp req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp result", rsp_result, 64'd0);
    chk("rst_resp alu_op", 64'(alu_operation), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      v.name = "rand";
      v.opc = (sel < 3) ? T_OP : (sel < 6) ? T_IMM : (sel < 9) ? T_BR : 7'($urandom);
      v.f3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    v.f7 = 7'h00;
        2:       v.f7 = 7'h20;
        default: v.f7 = 7'($urandom);
      endcase
      if (v.opc == T_IMM) v.f7[0] = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       begin v.rs1 = MINV; v.rs2 = 64'($urandom_range(0, 3)); end
        1:       begin v.rs1 = {$urandom, $urandom}; v.rs2 = v.rs1; end
        default: begin v.rs1 = {$urandom, $urandom}; v.rs2 = {$urandom, $urandom}; end
      endcase
      v.imm = {{52{v.f7[6]}}, v.f7, 5'($urandom)};
      v.e = ref_model(v.opc, v.f3, v.f7, v.rs1, v.rs2, v.imm);
      run_txn(v, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
